// File: rtl/expmul_row_sched.sv
// Per-query-row scheduler: tracks the running max, issues one expmul transaction
// per key and accumulates o_star lane-wise with saturation until the row's last key.
//
// state | meaning
// IDLE  | ready for the next key of the row
// ISSUE | expmul request presented, waiting for em_rdy_in
// WAIT  | request accepted, waiting for the expmul result
// EMIT  | row result presented, waiting for o_rdy_in

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 3
`endif

module expmul_row_sched #(
   parameter int DIM = `MAX_EMBEDDING_DIM + 1,
   parameter int VW  = 27,
   parameter int SW  = 9,
   parameter int CW  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_vld_in,
   output logic              s_rdy_out,
   input  logic [SW-1:0]     s_in,
   input  logic [DIM*VW-1:0] v_star_in,
   input  logic              last_in,
   output logic              em_vld_out,
   input  logic              em_rdy_in,
   output logic [SW-1:0]     em_m_out,
   output logic [SW-1:0]     em_m_prev_out,
   output logic [SW-1:0]     em_s_out,
   output logic [DIM*VW-1:0] em_o_star_prev_out,
   output logic [DIM*VW-1:0] em_v_star_out,
   input  logic              em_vld_in,
   output logic              em_rdy_out,
   input  logic [DIM*VW-1:0] em_exp_v_in,
   input  logic [DIM*VW-1:0] em_exp_o_in,
   output logic              o_vld_out,
   input  logic              o_rdy_in,
   output logic [DIM*VW-1:0] o_star_out,
   output logic [SW-1:0]     row_max_out,
   output logic [CW-1:0]     key_count_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

   state_t              state;
   logic [SW-1:0]       s_reg;
   logic [SW-1:0]       m_prev_reg;
   logic [SW-1:0]       m_new_reg;
   logic [SW-1:0]       m_reg;
   logic [DIM*VW-1:0]   v_reg;
   logic [DIM*VW-1:0]   o_reg;
   logic [DIM*VW-1:0]   o_sum;
   logic                last_reg;
   logic                first;
   logic [CW-1:0]       key_count;

   function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW:0] sum;
      sum = {a[VW-1], a} + {b[VW-1], b};
      if (sum[VW] != sum[VW-1])
         sat_add = sum[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
      else
         sat_add = sum[VW-1:0];
   endfunction

   always_comb begin
      o_sum = '0;
      for (int i = 0; i < DIM; i++)
         o_sum[i*VW +: VW] = sat_add(em_exp_o_in[i*VW +: VW], em_exp_v_in[i*VW +: VW]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         s_reg      <= '0;
         m_prev_reg <= '0;
         m_new_reg  <= '0;
         m_reg      <= '0;
         v_reg      <= '0;
         o_reg      <= '0;
         last_reg   <= 1'b0;
         first      <= 1'b1;
         key_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_vld_in) begin
                  s_reg    <= s_in;
                  v_reg    <= v_star_in;
                  last_reg <= last_in;
                  if (first) begin
                     m_prev_reg <= s_in;
                     m_new_reg  <= s_in;
                  end else begin
                     m_prev_reg <= m_reg;
                     // ties keep m_reg so the exp_o scale stays exactly 1.0
                     m_new_reg  <= ($signed(s_in) > $signed(m_reg)) ? s_in : m_reg;
                  end
                  if (key_count != {CW{1'b1}})
                     key_count <= key_count + 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (em_rdy_in)
                  state <= WAIT;
            end
            WAIT: begin
               if (em_vld_in) begin
                  o_reg <= o_sum;
                  m_reg <= m_new_reg;
                  first <= 1'b0;
                  state <= last_reg ? EMIT : IDLE;
               end
            end
            EMIT: begin
               if (o_rdy_in) begin
                  o_reg     <= '0;
                  first     <= 1'b1;
                  key_count <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign s_rdy_out          = (state == IDLE);
   assign em_vld_out         = (state == ISSUE);
   assign em_rdy_out         = (state == WAIT);
   assign o_vld_out          = (state == EMIT);
   assign em_m_out           = m_new_reg;
   assign em_m_prev_out      = m_prev_reg;
   assign em_s_out           = s_reg;
   assign em_o_star_prev_out = o_reg;
   assign em_v_star_out      = v_reg;
   assign o_star_out         = o_reg;
   assign row_max_out        = m_reg;
   assign key_count_out      = key_count;

endmodule

// File: tb/tb_expmul_row_sched.sv
// Directed bench for expmul_row_sched: the bench plays both upstream and the
// expmul unit, with hand-computed expected fields and accumulated lanes.

module tb_expmul_row_sched;

   localparam int DIM = 4;
   localparam int VW  = 27;
   localparam int SW  = 9;
   localparam int CW  = 16;
   localparam int DV  = DIM * VW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_vld_in = 1'b0;
   logic          s_rdy_out;
   logic [SW-1:0] s_in = '0;
   logic [DV-1:0] v_star_in = '0;
   logic          last_in = 1'b0;
   logic          em_vld_out;
   logic          em_rdy_in = 1'b0;
   logic [SW-1:0] em_m_out;
   logic [SW-1:0] em_m_prev_out;
   logic [SW-1:0] em_s_out;
   logic [DV-1:0] em_o_star_prev_out;
   logic [DV-1:0] em_v_star_out;
   logic          em_vld_in = 1'b0;
   logic          em_rdy_out;
   logic [DV-1:0] em_exp_v_in = '0;
   logic [DV-1:0] em_exp_o_in = '0;
   logic          o_vld_out;
   logic          o_rdy_in = 1'b0;
   logic [DV-1:0] o_star_out;
   logic [SW-1:0] row_max_out;
   logic [CW-1:0] key_count_out;

   int checks = 0;
   int errors = 0;

   expmul_row_sched #(.DIM(DIM), .VW(VW), .SW(SW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .s_vld_in(s_vld_in), .s_rdy_out(s_rdy_out), .s_in(s_in),
      .v_star_in(v_star_in), .last_in(last_in),
      .em_vld_out(em_vld_out), .em_rdy_in(em_rdy_in),
      .em_m_out(em_m_out), .em_m_prev_out(em_m_prev_out), .em_s_out(em_s_out),
      .em_o_star_prev_out(em_o_star_prev_out), .em_v_star_out(em_v_star_out),
      .em_vld_in(em_vld_in), .em_rdy_out(em_rdy_out),
      .em_exp_v_in(em_exp_v_in), .em_exp_o_in(em_exp_o_in),
      .o_vld_out(o_vld_out), .o_rdy_in(o_rdy_in),
      .o_star_out(o_star_out), .row_max_out(row_max_out), .key_count_out(key_count_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [SW-1:0] sc(input int x);
      logic [31:0] t;
      t = x;
      return t[SW-1:0];
   endfunction

   function automatic logic [DV-1:0] vec(input int l0, input int l1, input int l2, input int l3);
      logic [31:0] t [4];
      logic [DV-1:0] r;
      t[0] = l0; t[1] = l1; t[2] = l2; t[3] = l3;
      r = '0;
      for (int i = 0; i < DIM; i++)
         r[i*VW +: VW] = t[i][VW-1:0];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_key(input int s, input logic [DV-1:0] v, input logic last);
      chk("s_rdy_idle", s_rdy_out, 1);
      s_vld_in  = 1'b1;
      s_in      = sc(s);
      v_star_in = v;
      last_in   = last;
      step();
      s_vld_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic issue(input int m, input int mp, input int s,
                        input logic [DV-1:0] oprev, input logic [DV-1:0] v);
      chk("em_vld", em_vld_out, 1);
      chk("em_m", em_m_out, sc(m));
      chk("em_m_prev", em_m_prev_out, sc(mp));
      chk("em_s", em_s_out, sc(s));
      chk("em_o_star_prev", em_o_star_prev_out, oprev);
      chk("em_v_star", em_v_star_out, v);
      chk("s_rdy_issue", s_rdy_out, 0);
      em_rdy_in = 1'b1;
      step();
      em_rdy_in = 1'b0;
      chk("em_rdy_wait", em_rdy_out, 1);
      chk("em_vld_wait", em_vld_out, 0);
   endtask

   task automatic result(input logic [DV-1:0] eo, input logic [DV-1:0] ev);
      em_vld_in   = 1'b1;
      em_exp_o_in = eo;
      em_exp_v_in = ev;
      step();
      em_vld_in = 1'b0;
   endtask

   task automatic emit(input logic [DV-1:0] o, input int mx, input int cnt);
      chk("o_vld", o_vld_out, 1);
      chk("o_star", o_star_out, o);
      chk("row_max", row_max_out, sc(mx));
      chk("key_count", key_count_out, cnt);
      o_rdy_in = 1'b1;
      step();
      o_rdy_in = 1'b0;
      chk("o_vld_after", o_vld_out, 0);
      chk("s_rdy_after", s_rdy_out, 1);
   endtask

   task automatic check_reset_state();
      chk("rst_s_rdy", s_rdy_out, 1);
      chk("rst_em_vld", em_vld_out, 0);
      chk("rst_em_rdy", em_rdy_out, 0);
      chk("rst_o_vld", o_vld_out, 0);
      chk("rst_em_m", em_m_out, 0);
      chk("rst_em_m_prev", em_m_prev_out, 0);
      chk("rst_em_s", em_s_out, 0);
      chk("rst_em_o_prev", em_o_star_prev_out, 0);
      chk("rst_em_v", em_v_star_out, 0);
      chk("rst_o_star", o_star_out, 0);
      chk("rst_row_max", row_max_out, 0);
      chk("rst_key_count", key_count_out, 0);
   endtask

   initial begin
      logic [DV-1:0] v;
      @(negedge clk);
      step();
      rst = 1'b0;
      check_reset_state();

      // single-key row
      v = vec(131072, 40, 0, 0);
      send_key(16, v, 1'b1);
      issue(16, 16, 16, '0, v);
      result('0, v);
      emit(v, 16, 1);

      // rising scores
      send_key(16, vec(1000, 2, 0, 0), 1'b0);
      issue(16, 16, 16, '0, vec(1000, 2, 0, 0));
      result('0, vec(1000, 2, 0, 0));
      send_key(48, vec(500, 7, 0, 0), 1'b1);
      issue(48, 16, 48, vec(1000, 2, 0, 0), vec(500, 7, 0, 0));
      result(vec(250, 1, 0, 0), vec(500, 7, 0, 0));
      emit(vec(750, 8, 0, 0), 48, 2);

      // falling scores
      send_key(48, vec(2000, 3, 0, 0), 1'b0);
      issue(48, 48, 48, '0, vec(2000, 3, 0, 0));
      result('0, vec(2000, 3, 0, 0));
      send_key(16, vec(300, 9, 0, 0), 1'b1);
      issue(48, 48, 16, vec(2000, 3, 0, 0), vec(300, 9, 0, 0));
      result(vec(2000, 3, 0, 0), vec(75, 1, 0, 0));
      emit(vec(2075, 4, 0, 0), 48, 2);

      // falling negative scores (signed compare)
      send_key(-32, vec(64, 0, 0, 0), 1'b0);
      issue(-32, -32, -32, '0, vec(64, 0, 0, 0));
      result('0, vec(64, 0, 0, 0));
      send_key(-64, vec(128, 5, 0, 0), 1'b1);
      issue(-32, -32, -64, vec(64, 0, 0, 0), vec(128, 5, 0, 0));
      result(vec(64, 0, 0, 0), vec(8, 1, 0, 0));
      emit(vec(72, 1, 0, 0), -32, 2);

      // lane saturation, both directions
      send_key(0, vec(1, 2, 3, 4), 1'b1);
      issue(0, 0, 0, '0, vec(1, 2, 3, 4));
      result(vec(10, (1 << 26) - 10, -(1 << 26) + 5, 3), vec(20, 100, -50, 4));
      emit(vec(30, (1 << 26) - 1, -(1 << 26), 7), 0, 1);

      // backpressure on both handshakes; upstream valid must not be consumed
      v = vec(11, 22, 33, 44);
      send_key(5, v, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_em_vld", em_vld_out, 1);
         chk("bp_em_m", em_m_out, sc(5));
         chk("bp_em_s", em_s_out, sc(5));
         chk("bp_em_v", em_v_star_out, v);
         chk("bp_s_rdy", s_rdy_out, 0);
         s_vld_in = 1'b1;
         s_in     = sc(100);
         step();
      end
      s_vld_in = 1'b0;
      issue(5, 5, 5, '0, v);
      result('0, v);
      for (int i = 0; i < 4; i++) begin
         s_vld_in = 1'b1;
         chk("bp_o_vld", o_vld_out, 1);
         chk("bp_o_star", o_star_out, v);
         chk("bp_row_max", row_max_out, sc(5));
         chk("bp_key_count", key_count_out, 1);
         chk("bp_s_rdy_emit", s_rdy_out, 0);
         step();
      end
      s_vld_in = 1'b0;
      emit(v, 5, 1);
      chk("cnt_cleared", key_count_out, 0);

      // reset in WAIT of key 2 of a 3-key row
      send_key(10, vec(7, 7, 7, 7), 1'b0);
      issue(10, 10, 10, '0, vec(7, 7, 7, 7));
      result('0, vec(7, 7, 7, 7));
      send_key(12, vec(9, 9, 9, 9), 1'b0);
      issue(12, 10, 12, vec(7, 7, 7, 7), vec(9, 9, 9, 9));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state();
      result(vec(999, 999, 999, 999), vec(1, 1, 1, 1));
      chk("late_res_o_star", o_star_out, 0);
      chk("late_res_em_rdy", em_rdy_out, 0);
      send_key(20, vec(3, 0, 0, 0), 1'b1);
      issue(20, 20, 20, '0, vec(3, 0, 0, 0));
      result('0, vec(3, 0, 0, 0));
      emit(vec(3, 0, 0, 0), 20, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
